aes_encrypt_iter: RTL and testbench
===================================

# aes_encrypt_iter

Iterative AES encryption core, parametrised for AES-128/192/256 through `Nk`, with one round per clock. It sits between the key-expansion block, which supplies the full round-key schedule, and the consumer of the ciphertext. It adds a valid/ready handshake on both sides, back-to-back block acceptance, output hold under backpressure and asynchronous reset. It reuses the existing `AddRoundKey`, `EncryptRound` and `LastEncryptRound` datapath modules.

## Interface
- `Nk`, default 4: key length in 32-bit words. Legal values are 4, 6, 8; any other value is an elaboration error.
- `Nr`, default `Nk + 6`: round count (10/12/14). Derived from `Nk`; never overridden independently.
- `clk`  input  1: single clock. All state changes on the rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `data`  input  128: plaintext block. Byte 0 is at [127:120].
- `allKeys`  input  `(Nr+1)*128`: round-key schedule. Round key i is at `allKeys[128*i +: 128]`.
- `in_valid`  input  1: `data` is presented.
- `in_ready`  output  1: the core accepts `data` this cycle.
- `out`  output  128: ciphertext. Valid only while `out_valid` is high.
- `out_valid`  output  1: ciphertext available.
- `out_ready`  input  1: the consumer takes `out` this cycle.
- `busy`  output  1: a block is in flight (RUN state).
- `round_idx`  output  4: current round number, for debug.

## Operation
- FSM states: IDLE, RUN, DONE.
- **Accept.** A block is accepted on a rising edge where `in_valid & in_ready` is high.
  - `in_ready = (IDLE) | (DONE & out_ready)`. `in_ready` is never high in RUN.
- **On accept:**
  - `state <= data ^ allKeys[127:0]` (initial AddRoundKey).
  - `round_idx <= 1`.
  - FSM goes to RUN.
- **RUN, `round_idx` r in 1..Nr-1:**
  - `state <= EncryptRound(state, key[r])`.
  - `round_idx <= r+1`.
- **RUN, r == Nr:**
  - `state <= LastEncryptRound(state, key[Nr])`.
  - FSM goes to DONE.
  - `round_idx` holds at Nr.
- **DONE:**
  - `out_valid = 1`, `out = state`.
  - `out` and `out_valid` stay stable while `out_ready` is low.
  - `out_ready` high with no new accept: go to IDLE, `round_idx <= 0`.
  - `out_ready` and `in_valid` both high: the output is handed off and the new block is accepted on the same edge, going straight to RUN. This is the simultaneous-event rule.
- **Key stability.** `allKeys` must be stable from the accept edge until the edge that completes round Nr. The core does not latch the schedule. Changing it mid-block yields undefined ciphertext but no FSM corruption.
- **Ignored input.** `in_valid` in RUN is ignored; `data` is not sampled.

## Timing
- **Reset.** While `rst_n` is low, regardless of `clk`:
  - FSM = IDLE, `state` = 0, `round_idx` = 0.
  - `out_valid` = 0, `busy` = 0, `in_ready` = 1.
- **Reset mid-block.** Asserting `rst_n` mid-block discards the block immediately; no `out_valid` pulse follows.
- **Latency.** `out_valid` rises Nr edges after the accept edge: 10/12/14 cycles for Nk = 4/6/8.
- **Throughput.** With `out_ready` tied high and `in_valid` continuous, one block is accepted every Nr+1 cycles.
- **`busy`.** High from the edge after accept through the edge that enters DONE. Low in IDLE and DONE.
- **Outputs.** All outputs are registered or decoded from FSM state. No combinational path from `data`/`allKeys` to `out`. Only `in_ready` depends combinationally on `out_ready`.

## Test plan
- **AES-128.** Nk=4, schedule for key `000102030405060708090a0b0c0d0e0f`, `data=00112233445566778899aabbccddeeff`. Required: `out=69c4e0d86a7b0430d8cdb78070b4c55a`, `out_valid` exactly 10 cycles after accept.
- **AES-192 and AES-256.**
  - Nk=6, key `000102…1617`, same plaintext: `out=dda97ca4864cdfe06eaf70a0ec0d7191`, latency 12.
  - Nk=8, key `000102…1e1f`, same plaintext: `out=8ea2b7ca516745bfeafc49904b496089`, latency 14.
- **Backpressure.** Hold `out_ready=0` for 20 cycles after `out_valid`. Required: `out` and `out_valid` stable, `in_ready=0`. Raise `out_ready`: one-cycle handoff, then IDLE with `in_ready=1`.
- **Back-to-back.** Present 3 blocks with `in_valid` and `out_ready` held high. Required: accepts every Nr+1 cycles, three correct ciphertexts, and `data` changes during RUN are ignored.
- **Reset mid-block.** Pull `rst_n` low at round 5, asynchronously between edges. Required: `busy`/`out_valid` clear immediately, `round_idx=0`, no stray `out_valid`. The next block encrypts correctly.

Source files
------------

// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryption core: AES-128/192/256 chosen by Nk, one round per
// clock, valid/ready handshakes on both sides. The key schedule is supplied
// externally and is not latched here.

// SubBytes followed by ShiftRows; shared by the full and the final round.
module AesSubShift (
    input  logic [127:0] state_in,
    output logic [127:0] state_out
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // Inverse as a^254 (zero maps to zero), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Byte n sits at [127-8n]; row r of column c is byte 4c+r, rows rotate left by r.
    always_comb begin
        state_out = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                state_out[127 - 8*(4*c + r) -: 8] =
                    sbox(state_in[127 - 8*(4*((c + r) % 4) + r) -: 8]);
            end
        end
    end
endmodule

// Plain XOR of the state with a round key.
module AddRoundKey (
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    output logic [127:0] state_out
);
    assign state_out = state_in ^ round_key;
endmodule

// Full round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
module EncryptRound (
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    output logic [127:0] state_out
);
    logic [127:0] shifted;
    logic [127:0] mixed;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    AesSubShift u_sub_shift (
        .state_in (state_in),
        .state_out(shifted)
    );

    // MixColumns applied to each 32-bit column independently.
    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32*c -: 32] = mix_column(shifted[127 - 32*c -: 32]);
        end
    end

    assign state_out = mixed ^ round_key;
endmodule

// Final round: no MixColumns.
module LastEncryptRound (
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    output logic [127:0] state_out
);
    logic [127:0] shifted;

    AesSubShift u_sub_shift (
        .state_in (state_in),
        .state_out(shifted)
    );

    assign state_out = shifted ^ round_key;
endmodule

module aes_encrypt_iter #(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [127:0]          data,
    input  logic [(Nr+1)*128-1:0] allKeys,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [127:0]          out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [3:0]            round_idx
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [3:0] LAST_ROUND = 4'(Nr);

    generate
        if (!((Nk == 4 || Nk == 6 || Nk == 8) && Nr == Nk + 6)) begin : g_bad_nk
            $error("aes_encrypt_iter: Nk must be 4, 6 or 8 and Nr must equal Nk + 6");
        end
    endgenerate

    logic [1:0]   fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] round_key;
    logic [127:0] ark_out;
    logic [127:0] enc_out;
    logic [127:0] last_out;
    logic         accept;

    // Select the key for the round being computed; constant slices keep it in range.
    always_comb begin
        round_key = '0;
        for (int i = 0; i <= Nr; i++) begin
            if (round_q == 4'(i)) round_key = allKeys[128*i +: 128];
        end
    end

    AddRoundKey u_ark (
        .state_in (data),
        .round_key(allKeys[127:0]),
        .state_out(ark_out)
    );

    EncryptRound u_round (
        .state_in (state_q),
        .round_key(round_key),
        .state_out(enc_out)
    );

    LastEncryptRound u_last (
        .state_in (state_q),
        .round_key(round_key),
        .state_out(last_out)
    );

    assign in_ready  = (fsm_q == IDLE) | ((fsm_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out       = state_q;
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q == RUN);
    assign round_idx = round_q;

    // Next state: an accept in DONE hands off the result and starts the new block on one edge.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        case (fsm_q)
            IDLE: begin
                if (accept) begin
                    state_d = ark_out;
                    round_d = 4'd1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                if (round_q == LAST_ROUND) begin
                    state_d = last_out;
                    fsm_d   = DONE;
                end else begin
                    state_d = enc_out;
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                if (accept) begin
                    state_d = ark_out;
                    round_d = 4'd1;
                    fsm_d   = RUN;
                end else if (out_ready) begin
                    round_d = 4'd0;
                    fsm_d   = IDLE;
                end
            end
            default: begin
                fsm_d   = IDLE;
                round_d = 4'd0;
            end
        endcase
    end

    // State registers; reset drops any block in flight at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end
endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: three instances (Nk = 4, 6, 8) fed from one
// driver thread, with a negedge monitor popping expected ciphertexts from
// per-instance queues filled by a byte-level AES reference model.
module tb_aes_encrypt_iter;
    typedef struct {
        logic [127:0] ct;
        int           acc;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [127:0]  data_s      [3];
    logic [1919:0] keys_s      [3];
    logic [255:0]  ckey_s      [3];
    logic          in_valid_s  [3];
    logic          out_ready_s [3];
    logic          in_ready_s  [3];
    logic [127:0]  out_s       [3];
    logic          out_valid_s [3];
    logic          busy_s      [3];
    logic [3:0]    round_s     [3];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   rand_or = 1'b0;
    bit   prev_v [3];
    logic [7:0] sbox [256];
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];
    exp_t mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    aes_encrypt_iter #(.Nk(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .data(data_s[0]), .allKeys(keys_s[0][1407:0]),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]), .out(out_s[0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .busy(busy_s[0]),
        .round_idx(round_s[0])
    );

    aes_encrypt_iter #(.Nk(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .data(data_s[1]), .allKeys(keys_s[1][1663:0]),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]), .out(out_s[1]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .busy(busy_s[1]),
        .round_idx(round_s[1])
    );

    aes_encrypt_iter #(.Nk(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .data(data_s[2]), .allKeys(keys_s[2][1919:0]),
        .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]), .out(out_s[2]),
        .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]), .busy(busy_s[2]),
        .round_idx(round_s[2])
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int s);
        logic [15:0] t;
        t = {b, b} << s;
        return t[15:8];
    endfunction

    // Walks the generator 3 and its inverse together to fill the S-box table.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [1919:0] expand_keys(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1919:0] res;
        int            nr;
        nr   = nk + 6;
        rcon = 8'h01;
        res  = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) res[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return res;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] key, input int nk);
        logic [1919:0] ks;
        logic [127:0]  rk;
        logic [127:0]  res;
        logic [7:0]    s [16];
        logic [7:0]    t [16];
        int            nr;
        nr = nk + 6;
        ks = expand_keys(key, nk);
        for (int n = 0; n < 16; n++) s[n] = pt[127 - 8*n -: 8] ^ ks[127 - 8*n -: 8];
        for (int r = 1; r <= nr; r++) begin
            rk = ks[128*r +: 128];
            for (int n = 0; n < 16; n++) t[n] = sbox[s[n]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[row + 4*c] = t[row + 4*((c + row) % 4)];
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int i = 0; i < 4; i++) t[i] = s[4*c + i];
                    for (int i = 0; i < 4; i++)
                        s[4*c + i] = xt(t[i]) ^ xt(t[(i+1)%4]) ^ t[(i+1)%4] ^ t[(i+2)%4] ^ t[(i+3)%4];
                end
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ rk[127 - 8*n -: 8];
        end
        res = '0;
        for (int n = 0; n < 16; n++) res[127 - 8*n -: 8] = s[n];
        return res;
    endfunction

    // ---------------- scoreboard helpers ----------------
    function automatic int nr_of(input int k);
        return 10 + 2*k;
    endfunction

    function automatic int q_size(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t q_front(input int k);
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic q_push(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic q_pop(input int k);
        case (k)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic q_clear(input int k);
        case (k)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic report_timeout(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got no event within the cycle bound, expected one", name);
    endtask

    // Monitor: checks busy, latency and ciphertext at handoff, and queues expectations on accept.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                q_clear(k);
                prev_v[k] = 1'b0;
            end else begin
                check_output($sformatf("busy%0d", k), 128'(busy_s[k]),
                             128'(q_size(k) > 0 && !out_valid_s[k]));
                if (out_valid_s[k] && !prev_v[k]) begin
                    if (q_size(k) == 0) begin
                        check_output($sformatf("stray_valid%0d", k), 128'(out_valid_s[k]), 128'(1'b0));
                    end else begin
                        mon_e = q_front(k);
                        check_output($sformatf("latency%0d", k), 128'(cyc), 128'(mon_e.acc + nr_of(k)));
                        check_output($sformatf("round_done%0d", k), 128'(round_s[k]), 128'(nr_of(k)));
                    end
                end
                if (out_valid_s[k] && out_ready_s[k]) begin
                    if (q_size(k) == 0) begin
                        check_output($sformatf("stray_out%0d", k), 128'(out_valid_s[k]), 128'(1'b0));
                    end else begin
                        mon_e = q_front(k);
                        check_output($sformatf("ciphertext%0d", k), out_s[k], mon_e.ct);
                        q_pop(k);
                    end
                end
                if (in_valid_s[k] && in_ready_s[k]) begin
                    mon_e.ct  = aes_ref(data_s[k], ckey_s[k], 4 + 2*k);
                    mon_e.acc = cyc + 1;
                    q_push(k, mon_e);
                end
                prev_v[k] = out_valid_s[k];
            end
        end
    end

    // ---------------- driver ----------------
    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_or) begin
            for (int k = 0; k < 3; k++) out_ready_s[k] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic apply_stimulus(input int k, input logic [127:0] pt, input logic [255:0] key);
        int n;
        n = 0;
        while (busy_s[k] && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) report_timeout("wait_not_busy");
        ckey_s[k]     = key;
        keys_s[k]     = expand_keys(key, 4 + 2*k);
        data_s[k]     = pt;
        in_valid_s[k] = 1'b1;
        n = 0;
        while (!in_ready_s[k] && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) report_timeout("wait_in_ready");
        tick();
        in_valid_s[k] = 1'b0;
        data_s[k]     = rand128();
    endtask

    task automatic drain();
        int n;
        rand_or = 1'b0;
        for (int k = 0; k < 3; k++) out_ready_s[k] = 1'b1;
        n = 0;
        while ((q_size(0) + q_size(1) + q_size(2)) != 0 && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) report_timeout("drain");
        tick();
    endtask

    task automatic kat(input int k, input logic [255:0] key, input logic [127:0] exp_ct);
        int n;
        out_ready_s[k] = 1'b1;
        apply_stimulus(k, 128'h00112233445566778899aabbccddeeff, key);
        n = 0;
        while (!out_valid_s[k] && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) report_timeout("kat_wait");
        check_output($sformatf("kat_latency%0d", k), 128'(n), 128'(nr_of(k)));
        check_output($sformatf("kat_out%0d", k), out_s[k], exp_ct);
        tick();
    endtask

    task automatic back_to_back(input int k);
        int acc_at [3];
        int got;
        int t;
        logic [255:0] key;
        drain();
        key            = {rand128(), rand128()};
        ckey_s[k]      = key;
        keys_s[k]      = expand_keys(key, 4 + 2*k);
        out_ready_s[k] = 1'b1;
        in_valid_s[k]  = 1'b1;
        got = 0;
        t   = 0;
        while (got < 3 && t < 200) begin
            data_s[k] = rand128();
            if (in_ready_s[k]) begin
                acc_at[got] = t;
                got++;
            end
            tick();
            t++;
        end
        in_valid_s[k] = 1'b0;
        if (got < 3) begin
            report_timeout("b2b_accepts");
        end else begin
            check_output($sformatf("b2b_gap_a%0d", k), 128'(acc_at[1] - acc_at[0]), 128'(nr_of(k) + 1));
            check_output($sformatf("b2b_gap_b%0d", k), 128'(acc_at[2] - acc_at[1]), 128'(nr_of(k) + 1));
        end
        drain();
    endtask

    task automatic backpressure();
        logic [127:0] pt;
        logic [255:0] key;
        logic [127:0] exp_ct;
        int n;
        drain();
        pt     = rand128();
        key    = {rand128(), rand128()};
        exp_ct = aes_ref(pt, key, 4);
        out_ready_s[0] = 1'b0;
        apply_stimulus(0, pt, key);
        n = 0;
        while (!out_valid_s[0] && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) report_timeout("bp_wait");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_output("bp_out", out_s[0], exp_ct);
            check_output("bp_valid", 128'(out_valid_s[0]), 128'(1'b1));
            check_output("bp_in_ready", 128'(in_ready_s[0]), 128'(1'b0));
        end
        @(posedge clk);
        #1;
        out_ready_s[0] = 1'b1;
        #1;
        check_output("bp_release_in_ready", 128'(in_ready_s[0]), 128'(1'b1));
        check_output("bp_release_valid", 128'(out_valid_s[0]), 128'(1'b1));
        tick();
        check_output("bp_idle_valid", 128'(out_valid_s[0]), 128'(1'b0));
        check_output("bp_idle_in_ready", 128'(in_ready_s[0]), 128'(1'b1));
        check_output("bp_idle_round", 128'(round_s[0]), 128'(4'd0));
    endtask

    task automatic reset_mid_block();
        int n;
        drain();
        apply_stimulus(0, rand128(), {rand128(), rand128()});
        n = 0;
        while (round_s[0] != 4'd5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) report_timeout("wait_round5");
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_busy", 128'(busy_s[0]), 128'(1'b0));
        check_output("rst_valid", 128'(out_valid_s[0]), 128'(1'b0));
        check_output("rst_round", 128'(round_s[0]), 128'(4'd0));
        check_output("rst_in_ready", 128'(in_ready_s[0]), 128'(1'b1));
        check_output("rst_state", out_s[0], 128'h0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check_output("rst_no_valid", 128'(out_valid_s[0]), 128'(1'b0));
        end
        kat(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    endtask

    // Main sequence: reset, known answers, backpressure, back-to-back, random traffic, reset mid-block.
    initial begin
        build_sbox();
        for (int k = 0; k < 3; k++) begin
            data_s[k]      = '0;
            keys_s[k]      = '0;
            ckey_s[k]      = '0;
            in_valid_s[k]  = 1'b0;
            out_ready_s[k] = 1'b1;
            prev_v[k]      = 1'b0;
        end
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_output($sformatf("reset_in_ready%0d", k), 128'(in_ready_s[k]), 128'(1'b1));
            check_output($sformatf("reset_valid%0d", k), 128'(out_valid_s[k]), 128'(1'b0));
            check_output($sformatf("reset_busy%0d", k), 128'(busy_s[k]), 128'(1'b0));
            check_output($sformatf("reset_round%0d", k), 128'(round_s[k]), 128'(4'd0));
            check_output($sformatf("reset_out%0d", k), out_s[k], 128'h0);
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();

        kat(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        kat(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
            128'hdda97ca4864cdfe06eaf70a0ec0d7191);
        kat(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
            128'h8ea2b7ca516745bfeafc49904b496089);

        backpressure();
        back_to_back(0);
        back_to_back(2);

        drain();
        rand_or = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 3; k++) apply_stimulus(k, rand128(), {rand128(), rand128()});
        end
        drain();

        reset_mid_block();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #500000;
        bad++;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
